// File: rtl/mfunc_dma_engine.sv
// mfunc_dma_engine: copies nwords 32-bit words from a 64-bit source to a 32-bit destination through a read-data FIFO
// Ports: params_* launch parameters and sticky done flag from/to the register block;
//        busy high while transferring; rd_req_* read request port; rd_rsp_* in-order read data;
//        wr_* valid/ready write port.
module mfunc_dma_engine #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        params_start,
  input  logic [31:0] params_saddr_l,
  input  logic [31:0] params_saddr_h,
  input  logic [31:0] params_daddr_l,
  input  logic [31:0] params_data_len,
  input  logic        params_wr_mode,
  input  logic        params_rd_mode,
  output logic        params_data_done,
  output logic        busy,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [63:0] rd_req_addr,
  input  logic        rd_rsp_valid,
  input  logic [31:0] rd_rsp_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic start_q, rd_fix, wr_fix;
  logic launch, rd_hs, wr_hs, push;
  logic [63:0] src;
  logic [31:0] dst;
  logic [29:0] nwords, rd_cnt, wr_cnt;
  logic [CW-1:0] outstanding, fifo_count;
  logic [CW:0] credit;
  logic [AW-1:0] wptr, rptr;
  logic [31:0] mem [FIFO_DEPTH];
  logic unused_len;
  assign unused_len = ^params_data_len[1:0];
  assign launch = params_start && !start_q && state != RUN;
  assign rd_hs = rd_req_valid && rd_req_ready;
  assign wr_hs = wr_valid && wr_ready;
  assign push = rd_rsp_valid && state == RUN;
  // Reads in flight plus buffered words never exceed the FIFO, so responses always have room.
  assign credit = {1'b0, outstanding} + {1'b0, fifo_count};
  assign rd_req_addr = src;
  assign wr_addr = dst;
  assign wr_data = mem[rptr];
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = launch ? (|params_data_len[31:2] ? RUN : DONE) :
               (state == RUN && wr_hs && wr_cnt + 30'd1 == nwords) ? DONE : state;
  always_comb begin
    busy = state == RUN;
    params_data_done = state == DONE;
    rd_req_valid = busy && rd_cnt < nwords && credit < (CW+1)'(FIFO_DEPTH);
    wr_valid = busy && fifo_count != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      src         <= '0;
      dst         <= '0;
      rd_fix      <= 1'b0;
      wr_fix      <= 1'b0;
      nwords      <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      start_q <= params_start;
      if (launch) begin
        src         <= {params_saddr_h, params_saddr_l};
        dst         <= params_daddr_l;
        rd_fix      <= params_rd_mode;
        wr_fix      <= params_wr_mode;
        nwords      <= params_data_len[31:2];
        rd_cnt      <= '0;
        wr_cnt      <= '0;
        outstanding <= '0;
        fifo_count  <= '0;
        wptr        <= '0;
        rptr        <= '0;
      end else begin
        if (rd_hs) begin
          rd_cnt <= rd_cnt + 30'd1;
          src    <= rd_fix ? src : src + 64'd4;
        end
        if (wr_hs) begin
          wr_cnt <= wr_cnt + 30'd1;
          dst    <= wr_fix ? dst : dst + 32'd4;
        end
        outstanding <= outstanding + CW'(rd_hs) - CW'(push);
        fifo_count  <= fifo_count + CW'(push) - CW'(wr_hs);
        wptr        <= wptr + AW'(push);
        rptr        <= rptr + AW'(wr_hs);
      end
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= rd_rsp_data;
endmodule
